// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared ConfigBits field offsets and filter counter width helper
package io_pkg;

  // Per-channel ConfigBits layout: bit c*IO_CFG_W + offset
  localparam int IO_CFG_OREG = 0;
  localparam int IO_CFG_FEN  = 1;
  localparam int IO_CFG_W    = 2;

  // Counter width for a filter of filt_cnt cycles; a one-cycle filter still needs a 1-bit counter
  function automatic int filt_cnt_w(input int filt_cnt);
    return (filt_cnt > 1) ? $clog2(filt_cnt) : 1;
  endfunction

endpackage

// File: rtl/io_in_filter.sv
// rtl/io_in_filter.sv - one pad input: synchroniser, glitch filter, history and optional edge detect (IO_EDGE_DETECT_EN)
module io_in_filter
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic fen,
  output logic o,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int            CW       = filt_cnt_w(FILT_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   f;
  logic [CW-1:0]          cnt;
  logic                   q_r;

  assign s = sync[SYNC_STAGES-1];

  // Metastability chain; the pad is asynchronous so only the last stage is used
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], pad};
  end

  // Accept a new level only after FILT_CNT consecutive differing samples; bypass follows s directly
  always_ff @(posedge clk) begin
    if (rst) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (!fen || (s == f)) begin
      f   <= s;
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      f   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle history of the filtered value
  always_ff @(posedge clk) begin
    if (rst) q_r <= 1'b0;
    else     q_r <= f;
  end

  assign o = f;
  assign q = q_r;

`ifdef IO_EDGE_DETECT_EN
  assign rise = f & ~q_r;
  assign fall = ~f & q_r;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/io_n_bidirectional_filtered.sv
// rtl/io_n_bidirectional_filtered.sv - NUM_CH bidirectional pad BEL with filtered inputs; edge pulses under IO_EDGE_DETECT_EN
// BelMap below lists the default four channels in channel order (OREG then FEN per channel).
(* FABulous, BelMap, OREG0=0, FEN0=1, OREG1=2, FEN1=3, OREG2=4, FEN2=5, OREG3=6, FEN3=7 *)
module io_n_bidirectional_filtered
  import io_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  (* FABulous, EXTERNAL, SHARED_PORT *)
  input  logic                         UserCLK,
  input  logic                         RST,
  input  logic [NUM_CH-1:0]            I,
  input  logic [NUM_CH-1:0]            T,
  output logic [NUM_CH-1:0]            O,
  output logic [NUM_CH-1:0]            Q,
  output logic [NUM_CH-1:0]            RISE,
  output logic [NUM_CH-1:0]            FALL,
  (* FABulous, EXTERNAL *)
  output logic [NUM_CH-1:0]            I_top,
  (* FABulous, EXTERNAL *)
  output logic [NUM_CH-1:0]            T_top,
  (* FABulous, EXTERNAL *)
  input  logic [NUM_CH-1:0]            O_top,
  input  logic [IO_CFG_W*NUM_CH-1:0]   ConfigBits
);

  logic [NUM_CH-1:0] i_reg;
  logic [NUM_CH-1:0] t_reg;

  // Output-path flops load every edge; OREG only selects whether the pad sees them
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      i_reg <= '0;
      t_reg <= '0;
    end else begin
      i_reg <= I;
      t_reg <= ~T;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic oreg;
    logic fen;

    assign oreg = ConfigBits[c*IO_CFG_W + IO_CFG_OREG];
    assign fen  = ConfigBits[c*IO_CFG_W + IO_CFG_FEN];

    // Pad enable is active high, so the fabric tristate is inverted on both paths
    assign I_top[c] = oreg ? i_reg[c] : I[c];
    assign T_top[c] = oreg ? t_reg[c] : ~T[c];

    io_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CNT    (FILT_CNT)
    ) u_in (
      .clk  (UserCLK),
      .rst  (RST),
      .pad  (O_top[c]),
      .fen  (fen),
      .o    (O[c]),
      .q    (Q[c]),
      .rise (RISE[c]),
      .fall (FALL[c])
    );
  end

endmodule

// File: tb/tb_io_n_bidirectional_filtered.sv
// tb/tb_io_n_bidirectional_filtered.sv - scoreboard bench for io_n_bidirectional_filtered
module tb_io_n_bidirectional_filtered;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int FILT   = 4;
  localparam int CFGW   = 2 * NUM_CH;

`ifdef IO_EDGE_DETECT_EN
  localparam int EDGE_PULSES = NUM_CH;
`else
  localparam int EDGE_PULSES = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] i_v, t_v, o, q, rise, fall, i_top, t_top, o_top;
  logic [CFGW-1:0]   cfg;

  always #5 clk = ~clk;

  io_n_bidirectional_filtered #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC),
    .FILT_CNT    (FILT)
  ) dut (
    .UserCLK    (clk),
    .RST        (rst),
    .I          (i_v),
    .T          (t_v),
    .O          (o),
    .Q          (q),
    .RISE       (rise),
    .FALL       (fall),
    .I_top      (i_top),
    .T_top      (t_top),
    .O_top      (o_top),
    .ConfigBits (cfg)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: filtered level, history, output-path flops, run lengths, pad sample queue
  logic [NUM_CH-1:0] fm, qm, im_r, tm_r;
  int                run [NUM_CH];
  logic [NUM_CH-1:0] sq [$];
  bit                armed = 1'b0;
  int                rise_seen;
  logic [NUM_CH-1:0] o_or;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the combinational pad path, advance the model, check registered outputs
  task automatic step(input logic r, input logic [NUM_CH-1:0] pad);
    logic [NUM_CH-1:0] s, exp_i, exp_t, exp_r, exp_f;
    int lim;
    rst   = r;
    o_top = pad;
    i_v   = NUM_CH'($urandom);
    t_v   = NUM_CH'($urandom);
    #1;
    if (armed) begin
      for (int c = 0; c < NUM_CH; c++) begin
        exp_i[c] = cfg[2*c] ? im_r[c] : i_v[c];
        exp_t[c] = cfg[2*c] ? tm_r[c] : ~t_v[c];
      end
      check("i_top", 32'(i_top), 32'(exp_i));
      check("t_top", 32'(t_top), 32'(exp_t));
    end
    @(posedge clk);
    if (r) begin
      fm   = '0;
      qm   = '0;
      im_r = '0;
      tm_r = '0;
      for (int c = 0; c < NUM_CH; c++) run[c] = 0;
      sq.delete();
      for (int k = 0; k < SYNC; k++) sq.push_back('0);
    end else begin
      sq.push_back(pad);
      s  = sq.pop_front();
      qm = fm;
      for (int c = 0; c < NUM_CH; c++) begin
        lim = cfg[2*c+1] ? FILT : 1;
        if (s[c] == fm[c]) begin
          run[c] = 0;
        end else begin
          run[c]++;
          if (run[c] >= lim) begin
            fm[c]  = s[c];
            run[c] = 0;
          end
        end
      end
      im_r = i_v;
      tm_r = ~t_v;
    end
    @(negedge clk);
`ifdef IO_EDGE_DETECT_EN
    exp_r = fm & ~qm;
    exp_f = ~fm & qm;
`else
    exp_r = '0;
    exp_f = '0;
`endif
    check("o",    32'(o),    32'(fm));
    check("q",    32'(q),    32'(qm));
    check("rise", 32'(rise), 32'(exp_r));
    check("fall", 32'(fall), 32'(exp_f));
    rise_seen += $countones(rise);
    o_or      |= o;
    armed      = 1'b1;
  endtask

  initial begin
    int lat;
    int flat;
    int hold [NUM_CH];
    logic [NUM_CH-1:0] pad_r;

    // Reset with pads high, all channels registered, filter off
    cfg       = CFGW'(8'b0101_0101);
    rise_seen = 0;
    o_or      = '0;
    repeat (3) step(1'b1, 4'hF);
    check("rst_o",     32'(o),     0);
    check("rst_q",     32'(q),     0);
    check("rst_rise",  32'(rise),  0);
    check("rst_fall",  32'(fall),  0);
    check("rst_i_top", 32'(i_top), 0);
    check("rst_t_top", 32'(t_top), 0);
    rise_seen = 0;
    repeat (5) step(1'b0, 4'hF);
    check("release_o",    32'(o), 32'(4'hF));
    check("release_rise", 32'(rise_seen), 32'(EDGE_PULSES));

    // Output modes: ch0 combinational, ch1 registered
    cfg = CFGW'(8'b0000_0100);
    repeat (8) step(1'b0, 4'h0);

    // Glitch reject: two 3-cycle pulses separated by one low cycle
    cfg = CFGW'(8'b1010_1010);
    repeat (8) step(1'b0, 4'h0);
    o_or      = '0;
    rise_seen = 0;
    repeat (3) step(1'b0, 4'hF);
    step(1'b0, 4'h0);
    repeat (3) step(1'b0, 4'hF);
    repeat (8) step(1'b0, 4'h0);
    check("reject_o",    32'(o_or), 0);
    check("reject_rise", 32'(rise_seen), 0);

    // Glitch accept: held high, then dropped
    rise_seen = 0;
    lat       = 0;
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 4'hF);
      if (lat == 0 && o == 4'hF) lat = n;
    end
    check("accept_lat",  32'(lat), 6);
    check("accept_rise", 32'(rise_seen), 32'(EDGE_PULSES));
    lat  = 0;
    flat = 0;
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 4'h0);
      if (lat == 0 && o == 4'h0) lat = n;
      if (flat == 0 && fall == 4'hF) flat = n;
    end
    check("drop_lat", 32'(lat), 6);
`ifdef IO_EDGE_DETECT_EN
    check("fall_lat", 32'(flat), 6);
`else
    check("fall_lat", 32'(flat), 0);
`endif

    // Filter disabled mid-count: O follows s on the next edge with a single pulse
    rise_seen = 0;
    repeat (4) step(1'b0, 4'hF);
    cfg = CFGW'(8'b0000_0000);
    step(1'b0, 4'hF);
    check("fen_toggle_o", 32'(o), 32'(4'hF));
    repeat (4) step(1'b0, 4'hF);
    check("fen_toggle_rise", 32'(rise_seen), 32'(EDGE_PULSES));

    // Reset with a partial count of 3 pending
    cfg = CFGW'(8'b1010_1010);
    repeat (8) step(1'b0, 4'h0);
    repeat (5) step(1'b0, 4'hF);
    o_or = '0;
    step(1'b1, 4'h0);
    repeat (10) step(1'b0, 4'h0);
    check("rst_mid_o", 32'(o_or), 0);

    // Independent channels: alternating pads with random hold lengths and mixed config
    pad_r = '0;
    for (int c = 0; c < NUM_CH; c++) hold[c] = c + 1;
    for (int n = 0; n < 300; n++) begin
      if (n % 40 == 0) cfg = CFGW'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        if (hold[c] == 0) begin
          pad_r[c] = ~pad_r[c];
          hold[c]  = $urandom_range(1, 7);
        end else begin
          hold[c]--;
        end
      end
      step(($urandom_range(0, 99) == 0), pad_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
